// File: rtl/regfile_pkg.sv
// Shared types and default constants for the parametrised MIPS register file.
// Optional write-through bypass is enabled by defining REGFILE_BYPASS_EN.
package regfile_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } rf_state_e;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int DEF_NUM_RD = 2;

    localparam int ZERO_ADDR  = 0;

endpackage

// File: rtl/regfile_clr_ctrl.sv
// Clear engine: walks every entry writing zero after reset or on request,
// then holds READY until the next clear request.
module regfile_clr_ctrl
    import regfile_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear_req,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr,
    output logic              ready,
    output logic              busy,
    output rf_state_e         state
);

    // Terminal count is the last entry (all ones), not pointer overflow.
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    rf_state_e         state_q, state_d;
    logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= CLEAR;
            clr_ptr_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        clr_we    = 1'b0;
        case (state_q)
            CLEAR: begin
                clr_we = 1'b1;
                if (clr_ptr_q == LAST_ADDR) begin
                    state_d   = READY;
                    clr_ptr_d = '0;
                end else begin
                    clr_ptr_d = clr_ptr_q + 1'b1;
                end
            end
            READY: begin
                if (clear_req) begin
                    state_d   = CLEAR;
                    clr_ptr_d = '0;
                end
            end
            default: begin
                state_d   = CLEAR;
                clr_ptr_d = '0;
            end
        endcase
    end

    assign clr_addr = clr_ptr_q;
    assign ready    = (state_q == READY);
    assign busy     = ~ready;
    assign state    = state_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file with rising-edge write, hardwired r0 and a
// sequential clear engine. Define REGFILE_BYPASS_EN for write-through reads.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int NUM_RD = DEF_NUM_RD
) (
    input  logic                     Clk,
    input  logic                     Rst_n,
    input  logic                     ClearReq,
    input  logic                     RegWrite,
    input  logic [ADDR_W-1:0]        RegWrAddr,
    input  logic [DATA_W-1:0]        RegWrData,
    input  logic [NUM_RD*ADDR_W-1:0] RegRdAddr,
    output logic [NUM_RD*DATA_W-1:0] RegRdData,
    output logic                     Ready,
    output logic                     Busy
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(ZERO_ADDR);

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    rf_state_e         clr_state;
    logic              wr_accept;
    logic              arr_we;
    logic [ADDR_W-1:0] arr_addr;
    logic [DATA_W-1:0] arr_data;

    regfile_clr_ctrl #(.ADDR_W(ADDR_W)) u_clr_ctrl (
        .clk       (Clk),
        .rst_n     (Rst_n),
        .clear_req (ClearReq),
        .clr_we    (clr_we),
        .clr_addr  (clr_addr),
        .ready     (Ready),
        .busy      (Busy),
        .state     (clr_state)
    );

    // A write coinciding with a clear request is dropped along with the clear start.
    assign wr_accept = (clr_state == READY) && RegWrite && (RegWrAddr != ZERO_A) && !ClearReq;

    always_comb begin
        arr_we   = 1'b0;
        arr_addr = RegWrAddr;
        arr_data = RegWrData;
        if (clr_we) begin
            arr_we   = 1'b1;
            arr_addr = clr_addr;
            arr_data = '0;
        end else if (wr_accept) begin
            arr_we = 1'b1;
        end
    end

    // Storage is deliberately not reset; the clear engine zeroes it instead.
    always_ff @(posedge Clk) begin
        if (arr_we) begin
            mem_q[arr_addr] <= arr_data;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] rd_addr;
        logic [DATA_W-1:0] rd_data;

        assign rd_addr = RegRdAddr[k*ADDR_W +: ADDR_W];

        always_comb begin
            rd_data = '0;
            if ((rd_addr != ZERO_A) && (clr_state == READY)) begin
                rd_data = mem_q[rd_addr];
`ifdef REGFILE_BYPASS_EN
                if (wr_accept && (rd_addr == RegWrAddr)) begin
                    rd_data = RegWrData;
                end
`endif
            end
        end

        assign RegRdData[k*DATA_W +: DATA_W] = rd_data;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp with default parameters.
module tb_regfile_mp;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NUM_RD = 2;

    logic                     Clk;
    logic                     Rst_n;
    logic                     ClearReq;
    logic                     RegWrite;
    logic [ADDR_W-1:0]        RegWrAddr;
    logic [DATA_W-1:0]        RegWrData;
    logic [NUM_RD*ADDR_W-1:0] RegRdAddr;
    logic [NUM_RD*DATA_W-1:0] RegRdData;
    logic                     Ready;
    logic                     Busy;

    logic [DATA_W-1:0] rd0;
    logic [DATA_W-1:0] rd1;

    int tests;
    int fails;

    assign rd0 = RegRdData[0 +: DATA_W];
    assign rd1 = RegRdData[DATA_W +: DATA_W];

    regfile_mp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD)) dut (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .ClearReq  (ClearReq),
        .RegWrite  (RegWrite),
        .RegWrAddr (RegWrAddr),
        .RegWrData (RegWrData),
        .RegRdAddr (RegRdAddr),
        .RegRdData (RegRdData),
        .Ready     (Ready),
        .Busy      (Busy)
    );

    // clock / reset
    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // driver tasks; inputs change 1 time unit after the rising edge
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic set_rd(input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1);
        RegRdAddr = {a1, a0};
    endtask

    task automatic write_reg(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        RegWrite  = 1'b1;
        RegWrAddr = a;
        RegWrData = d;
        tick();
        RegWrite  = 1'b0;
    endtask

    task automatic test_reset();
        int n;
        Rst_n = 1'b0;
        set_rd(5'd5, 5'd31);
        #2;
        tests++;
        if (Ready !== 1'b0 || Busy !== 1'b1) begin
            fails++;
            $display("FAIL reset_flags: got Ready=%b Busy=%b, expected Ready=0 Busy=1", Ready, Busy);
        end
        tests++;
        if (RegRdData !== '0) begin
            fails++;
            $display("FAIL reset_rddata: got %h expected 0", RegRdData);
        end
        tick();
        tick();
        Rst_n = 1'b1;
        n = 0;
        while (Ready !== 1'b1 && n < 64) begin
            tick();
            n++;
            if (Ready !== 1'b1) begin
                tests++;
                if (rd0 !== '0 || Busy !== 1'b1) begin
                    fails++;
                    $display("FAIL reset_clear_phase: edge %0d got rd0=%h Busy=%b, expected 0 and 1", n, rd0, Busy);
                end
            end
        end
        tests++;
        if (n != 32) begin
            fails++;
            $display("FAIL reset_clear_len: got %0d edges expected 32", n);
        end
        for (int a = 0; a < 32; a += 2) begin
            set_rd(5'(a), 5'(a + 1));
            #1;
            tests++;
            if (rd0 !== '0 || rd1 !== '0) begin
                fails++;
                $display("FAIL reset_read_all: addr %0d got %h/%h expected 0", a, rd0, rd1);
            end
        end
    endtask

    task automatic test_write_read();
        write_reg(5'd5, 32'hDEADBEEF);
        set_rd(5'd5, 5'd5);
        #1;
        tests++;
        if (rd0 !== 32'hDEADBEEF || rd1 !== 32'hDEADBEEF) begin
            fails++;
            $display("FAIL write_read_r5: got %h/%h expected deadbeef", rd0, rd1);
        end
    endtask

    task automatic test_r0();
        write_reg(5'd0, 32'h12345678);
        set_rd(5'd0, 5'd5);
        #1;
        tests++;
        if (rd0 !== 32'h0 || rd1 !== 32'hDEADBEEF) begin
            fails++;
            $display("FAIL r0_hardwired: got %h/%h expected 0/deadbeef", rd0, rd1);
        end
    endtask

    task automatic test_same_cycle();
        logic [DATA_W-1:0] exp_v;
`ifdef REGFILE_BYPASS_EN
        exp_v = 32'hA5A5A5A5;
`else
        exp_v = 32'h0;
`endif
        set_rd(5'd7, 5'd5);
        RegWrite  = 1'b1;
        RegWrAddr = 5'd7;
        RegWrData = 32'hA5A5A5A5;
        #1;
        tests++;
        if (rd0 !== exp_v || rd1 !== 32'hDEADBEEF) begin
            fails++;
            $display("FAIL same_cycle_r7: got %h/%h expected %h/deadbeef", rd0, rd1, exp_v);
        end
        tick();
        RegWrite = 1'b0;
        #1;
        tests++;
        if (rd0 !== 32'hA5A5A5A5) begin
            fails++;
            $display("FAIL after_write_r7: got %h expected a5a5a5a5", rd0);
        end
    endtask

    task automatic test_back_to_back();
        write_reg(5'd1, 32'h11111111);
        write_reg(5'd2, 32'h22222222);
        write_reg(5'd1, 32'h33333333);
        set_rd(5'd1, 5'd2);
        #1;
        tests++;
        if (rd0 !== 32'h33333333 || rd1 !== 32'h22222222) begin
            fails++;
            $display("FAIL back_to_back: got %h/%h expected 33333333/22222222", rd0, rd1);
        end
    endtask

    task automatic test_clear();
        int n;
        for (int a = 1; a < 32; a++) begin
            write_reg(5'(a), 32'h01010101 * a + 32'h80000000);
        end
        set_rd(5'd31, 5'd9);
        #1;
        tests++;
        if (rd0 !== 32'h9F1F1F1F || rd1 !== 32'h89090909) begin
            fails++;
            $display("FAIL fill_readback: got %h/%h expected 9f1f1f1f/89090909", rd0, rd1);
        end
        // write on the ClearReq cycle must be dropped
        ClearReq  = 1'b1;
        RegWrite  = 1'b1;
        RegWrAddr = 5'd3;
        RegWrData = 32'hCAFEF00D;
        tick();
        ClearReq = 1'b0;
        RegWrite = 1'b0;
        n = 0;
        while (Ready !== 1'b1 && n < 64) begin
            tests++;
            if (Busy !== 1'b1 || rd0 !== '0 || rd1 !== '0) begin
                fails++;
                $display("FAIL clear_phase: cycle %0d got Busy=%b rd=%h/%h expected 1,0,0", n, Busy, rd0, rd1);
            end
            RegWrite  = (n == 5);
            RegWrAddr = 5'd9;
            RegWrData = 32'hBAADF00D;
            set_rd(5'(n), 5'd9);
            tick();
            n++;
        end
        RegWrite = 1'b0;
        tests++;
        if (n != 32) begin
            fails++;
            $display("FAIL clear_len: got %0d edges expected 32", n);
        end
        set_rd(5'd9, 5'd3);
        #1;
        tests++;
        if (rd0 !== '0 || rd1 !== '0) begin
            fails++;
            $display("FAIL clear_dropped_writes: got r9=%h r3=%h expected 0", rd0, rd1);
        end
        set_rd(5'd31, 5'd16);
        #1;
        tests++;
        if (rd0 !== '0 || rd1 !== '0) begin
            fails++;
            $display("FAIL clear_zeroed: got r31=%h r16=%h expected 0", rd0, rd1);
        end
        write_reg(5'd9, 32'h00C0FFEE);
        set_rd(5'd9, 5'd0);
        #1;
        tests++;
        if (rd0 !== 32'h00C0FFEE) begin
            fails++;
            $display("FAIL write_after_clear: got %h expected 00c0ffee", rd0);
        end
    endtask

    task automatic test_reset_mid_clear();
        int n;
        ClearReq = 1'b1;
        tick();
        ClearReq = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
        end
        // ClearReq while already clearing must not restart the pointer
        ClearReq = 1'b1;
        tick();
        ClearReq = 1'b0;
        #2;
        Rst_n = 1'b0;
        #1;
        tests++;
        if (Ready !== 1'b0 || Busy !== 1'b1 || rd0 !== '0) begin
            fails++;
            $display("FAIL mid_clear_reset: got Ready=%b Busy=%b rd0=%h expected 0,1,0", Ready, Busy, rd0);
        end
        tick();
        Rst_n = 1'b1;
        n = 0;
        while (Ready !== 1'b1 && n < 64) begin
            tick();
            n++;
        end
        tests++;
        if (n != 32) begin
            fails++;
            $display("FAIL mid_clear_restart_len: got %0d edges expected 32", n);
        end
    endtask

    task automatic test_clear_req_ignored_in_clear();
        int n;
        ClearReq = 1'b1;
        tick();
        ClearReq = 1'b0;
        n = 0;
        while (Ready !== 1'b1 && n < 64) begin
            ClearReq = (n == 20);
            tick();
            n++;
        end
        ClearReq = 1'b0;
        tests++;
        if (n != 32) begin
            fails++;
            $display("FAIL clearreq_in_clear: got %0d edges expected 32", n);
        end
    endtask

    initial begin
        tests     = 0;
        fails     = 0;
        Rst_n     = 1'b0;
        ClearReq  = 1'b0;
        RegWrite  = 1'b0;
        RegWrAddr = '0;
        RegWrData = '0;
        RegRdAddr = '0;
        #1;
        test_reset();
        test_write_read();
        test_r0();
        test_same_cycle();
        test_back_to_back();
        test_clear();
        test_reset_mid_clear();
        test_clear_req_ignored_in_clear();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised general-purpose register file for the MIPS datapath. It replaces the fixed 32×32, two-read-port, negedge-write file. It provides a configurable width, depth and read-port count, and writes on the rising edge. A sequential clear engine zeroes every entry after reset or on request. Register 0 is hardwired to zero. The file sits between the decode stage (read ports) and the write-back stage (write port).

## Interface
Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries
- NUM_RD, 2, number of independent read ports (1..4)

Ports:
- Clk  in  1  clock; all state updates on rising edge
- Rst_n  in  1  asynchronous, active-low reset
- ClearReq  in  1  one-cycle pulse; restarts the clear sequence (honoured only when Ready=1)
- RegWrite  in  1  write enable
- RegWrAddr  in  ADDR_W  write address
- RegWrData  in  DATA_W  write data
- RegRdAddr  in  NUM_RD*ADDR_W  packed read addresses; port k uses bits [k*ADDR_W +: ADDR_W]
- RegRdData  out  NUM_RD*DATA_W  packed read data; port k uses bits [k*DATA_W +: DATA_W]
- Ready  out  1  1 = file initialised and accepting writes
- Busy  out  1  1 = clear sequence in progress (always ~Ready)

## Operation
- FSM has two states:
  - CLEAR: ClrPtr walks 0..DEPTH-1, writing 0 to entry ClrPtr each cycle. The transition to READY happens on the edge that clears entry DEPTH-1.
  - READY: ClearReq=1 moves to CLEAR and sets ClrPtr=0.
- Rst_n=0 (async): state=CLEAR, ClrPtr=0, Ready=0, Busy=1. The storage array itself is not reset.
- Writes:
  - Accepted only when state=READY, RegWrite=1 and RegWrAddr!=0.
  - Writes in CLEAR are dropped silently. A write in the same cycle as ClearReq is also dropped.
- Reads (combinational, every port independent):
  - Address 0 → 0.
  - state=CLEAR → 0 for all addresses.
  - Otherwise → stored entry, or the bypass value (see Configuration).
- Reset asserted mid-clear or mid-write: the sequence restarts from ClrPtr=0. A partially applied write is irrelevant because the entry is re-cleared.
- ClearReq while already in CLEAR is ignored; the pointer is not restarted.
- ClrPtr is ADDR_W bits wide. The terminal count is detected at DEPTH-1, not by overflow.

## Timing
- Write latency: data is stored on the rising edge where the write is accepted. A read in the next cycle returns it.
- Read latency: 0 cycles (combinational from RegRdAddr and the stored array).
- Clear duration: exactly DEPTH rising edges after Rst_n deasserts, or after the ClearReq edge. Ready rises after the DEPTH-th edge (32 cycles for the defaults).
- Reset values: Ready=0, Busy=1, RegRdData=0 (all ports).

## Configuration
- REGFILE_BYPASS_EN defined:
  - When a write is accepted in the current cycle and RegRdAddr[k]==RegWrAddr (nonzero), port k returns RegWrData combinationally (write-through).
  - This removes the need for the former negedge-write trick.
- Undefined: port k returns the old stored value in that cycle. The hazard is left to the forwarding unit.

## Structure
- Shared package regfile_pkg holds:
  - the state encoding typedef (CLEAR, READY)
  - default parameter constants (DATA_W, ADDR_W, NUM_RD)
  - a ZERO_ADDR constant
- One sub-module: regfile_clr_ctrl, containing the FSM, ClrPtr and Ready/Busy generation. It outputs a clear-write strobe and address to the array.
- Read muxes are generated per port in the top module.

## Test plan
- Reset release, defaults → Ready=0 for 32 cycles, then Ready=1. Reading every address returns 0.
- Ready=1, write 0xDEADBEEF to r5, next cycle read r5 on both ports → 0xDEADBEEF on each.
- Write 0x12345678 to r0, then read r0 → 0x00000000.
- Same-cycle write 0xA5A5A5A5 to r7 with read r7:
  - with REGFILE_BYPASS_EN → 0xA5A5A5A5
  - without it → previous value 0
- Fill r1..r31 with nonzero values, pulse ClearReq → Busy=1 for 32 cycles and reads return 0 throughout. A write issued during clear is dropped, so r9 reads 0 after Ready.
- Assert Rst_n=0 at clear cycle 10, release → the full 32-cycle clear restarts and Ready rises only after the 32nd edge.
